// File: rtl/eth_burst_sched.sv
// Descriptor-driven sequencer for a one-cycle-latency burst reader: queues (addr, len)
// descriptors, pulses the reader start, and forwards exactly len beats downstream.
module eth_burst_sched #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 8,
   parameter int LEN_W    = 8,
   parameter int QDEPTH_W = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                desc_valid,
   output logic                desc_ready,
   input  logic [ADDR_W-1:0]   desc_addr,
   input  logic [LEN_W-1:0]    desc_len,
   input  logic                abort,
   output logic                burst_start,
   output logic [ADDR_W-1:0]   burst_start_addr,
   input  logic [DATA_W-1:0]   rd_data,
   input  logic                rd_valid,
   output logic                rd_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_last,
   output logic                done,
   output logic [QDEPTH_W:0]   q_level,
   output logic [15:0]         bursts_done
);

   localparam int QDEPTH = 1 << QDEPTH_W;
   localparam logic [QDEPTH_W:0] Q_FULL_LVL = (QDEPTH_W + 1)'(QDEPTH);

   typedef enum logic [1:0] {IDLE, START, ARM, STREAM} state_t;

   // Handshakes: a transfer happens on a cycle where valid and ready are both high;
   // valid never waits for ready, and data is held stable while valid is high and ready low.

   state_t              state;
   logic [ADDR_W-1:0]   q_addr [QDEPTH];
   logic [LEN_W-1:0]    q_len  [QDEPTH];
   logic [QDEPTH_W-1:0] wr_ptr;
   logic [QDEPTH_W-1:0] rd_ptr;
   logic [LEN_W-1:0]    remaining;
   logic                init_done;
   logic                push;
   logic                pop;
   logic                hs;
   logic                in_stream;
   logic [ADDR_W-1:0]   head_addr;
   logic [LEN_W-1:0]    head_len;

   assign in_stream  = (state == STREAM);
   assign desc_ready = init_done & (q_level != Q_FULL_LVL) & ~abort;
   assign push       = desc_valid & desc_ready;
   assign pop        = (state == IDLE) & (q_level != '0) & ~abort;
   assign hs         = in_stream & rd_valid & out_ready;
   assign head_addr  = q_addr[rd_ptr];
   assign head_len   = q_len[rd_ptr];

   assign out_data  = rd_data;
   assign out_valid = in_stream & rd_valid;
   assign rd_ready  = in_stream & out_ready;
   assign out_last  = in_stream & (remaining == LEN_W'(1));

   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[wr_ptr] <= desc_addr;
         q_len[wr_ptr]  <= desc_len;
      end
   end

   // Abort flushes by rewinding both pointers; pushes are already blocked that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_level <= '0;
      end else if (abort) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      q_level <= q_level + 1'b1;
         else if (pop && !push) q_level <= q_level - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         remaining        <= '0;
         init_done        <= 1'b0;
         burst_start      <= 1'b0;
         burst_start_addr <= '0;
         done             <= 1'b0;
         bursts_done      <= '0;
      end else begin
         init_done        <= 1'b1;
         burst_start      <= 1'b0;
         burst_start_addr <= '0;
         done             <= 1'b0;
         if (abort) begin
            state     <= IDLE;
            remaining <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (pop) begin
                     if (head_len != '0) begin
                        state            <= START;
                        remaining        <= head_len;
                        burst_start      <= 1'b1;
                        burst_start_addr <= head_addr;
                     end else begin
                        done        <= 1'b1;
                        bursts_done <= bursts_done + 16'd1;
                     end
                  end
               end
               START: state <= ARM;
               // Reader is initialising; any rd_valid seen here is stale.
               ARM:   state <= STREAM;
               STREAM: begin
                  if (hs) begin
                     if (remaining <= LEN_W'(1)) begin
                        state       <= IDLE;
                        remaining   <= '0;
                        done        <= 1'b1;
                        bursts_done <= bursts_done + 16'd1;
                     end else begin
                        remaining <= remaining - 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_eth_burst_sched.sv
// Bench for eth_burst_sched: a behavioural burst reader feeds the DUT; delivered
// beats are checked against an expected queue filled when descriptors are accepted.
module tb_eth_burst_sched;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 8;
   localparam int LEN_W    = 8;
   localparam int QDEPTH_W = 2;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                desc_valid = 1'b0;
   logic                desc_ready;
   logic [ADDR_W-1:0]   desc_addr = '0;
   logic [LEN_W-1:0]    desc_len = '0;
   logic                abort = 1'b0;
   logic                burst_start;
   logic [ADDR_W-1:0]   burst_start_addr;
   logic [DATA_W-1:0]   rd_data;
   logic                rd_valid;
   logic                rd_ready;
   logic [DATA_W-1:0]   out_data;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic                out_last;
   logic                done;
   logic [QDEPTH_W:0]   q_level;
   logic [15:0]         bursts_done;

   eth_burst_sched #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .QDEPTH_W(QDEPTH_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_addr(desc_addr), .desc_len(desc_len), .abort(abort),
      .burst_start(burst_start), .burst_start_addr(burst_start_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .done(done), .q_level(q_level), .bursts_done(bursts_done)
   );

   always #5 clk = ~clk;

   // Burst reader: one cycle after a start pulse it presents mem[addr] and advances on ready.
   logic [DATA_W-1:0] mem [256];
   logic [ADDR_W-1:0] rdr_addr;
   logic              rdr_act;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdr_addr <= '0;
         rdr_act  <= 1'b0;
      end else if (burst_start) begin
         rdr_addr <= burst_start_addr;
         rdr_act  <= 1'b1;
      end else if (rdr_act && rd_ready) begin
         rdr_addr <= rdr_addr + 1'b1;
      end
   end

   assign rd_valid = rdr_act;
   assign rd_data  = mem[rdr_addr];

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
      logic              exp_start;
   } vec_t;

   vec_t              tbl [5];
   logic [DATA_W:0]   exp_q [$];
   int                errors = 0;
   int                checks = 0;
   int                hs_cnt = 0;
   int                start_cnt = 0;
   int                done_cnt = 0;
   int                exp_done = 0;
   int                since_start = 0;
   bit                in_burst = 1'b0;
   logic [ADDR_W-1:0] last_start_addr = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sample();
      logic [DATA_W:0] e;
      if (!rst_n) return;
      if (burst_start) begin
         start_cnt++;
         last_start_addr = burst_start_addr;
         in_burst = 1'b1;
         since_start = 0;
      end else begin
         since_start++;
      end
      if (done) done_cnt++;
      if (rd_ready) check("rd_ready_window", 32'(in_burst && since_start >= 2), 32'd1);
      if (out_valid && out_ready) begin
         hs_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_beat: got data 0x%0h with no beat expected", out_data);
         end else begin
            e = exp_q.pop_front();
            check("beat_data", out_data, e[DATA_W-1:0]);
            check("beat_last", 32'(out_last), 32'(e[DATA_W]));
            if (e[DATA_W]) in_burst = 1'b0;
         end
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_beats(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
      logic [ADDR_W-1:0] a;
      for (int j = 0; j < int'(len); j++) begin
         a = addr + ADDR_W'(j);
         exp_q.push_back({(j == int'(len) - 1), mem[a]});
      end
   endtask

   task automatic push_desc(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
      bit ok = 1'b0;
      int n = 0;
      desc_addr  = addr;
      desc_len   = len;
      desc_valid = 1'b1;
      while (!ok && n < 60) begin
         if (desc_ready) begin
            expect_beats(addr, len);
            ok = 1'b1;
         end
         cyc();
         n++;
      end
      desc_valid = 1'b0;
      check("push_accepted", 32'(ok), 32'd1);
   endtask

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         cyc();
         n++;
      end
      check("done_count", 32'(done_cnt), 32'(target));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      int s0;
      logic [5:0] pat;

      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      tbl[0] = '{addr: 8'h20, len: 8'd0, exp_start: 1'b0};
      tbl[1] = '{addr: 8'h30, len: 8'd2, exp_start: 1'b1};
      tbl[2] = '{addr: 8'h80, len: 8'd1, exp_start: 1'b1};
      tbl[3] = '{addr: 8'hFE, len: 8'd3, exp_start: 1'b1};
      tbl[4] = '{addr: 8'h00, len: 8'd5, exp_start: 1'b1};

      // Reset values
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_desc_ready", 32'(desc_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_rd_ready", 32'(rd_ready), 32'd0);
      check("rst_burst_start", 32'(burst_start), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_q_level", 32'(q_level), 32'd0);
      check("rst_bursts_done", 32'(bursts_done), 32'd0);
      check("rst_out_data", out_data, mem[0]);
      rst_n = 1'b1;
      #1;
      check("desc_ready_before_edge", 32'(desc_ready), 32'd0);
      cyc();
      check("desc_ready_after_release", 32'(desc_ready), 32'd1);

      // Single descriptor latency: push in cycle 0
      desc_addr = 8'h10; desc_len = 8'd4; desc_valid = 1'b1;
      expect_beats(8'h10, 8'd4);
      cyc();
      desc_valid = 1'b0;
      check("c1_q_level", 32'(q_level), 32'd1);
      check("c1_no_start", 32'(burst_start), 32'd0);
      cyc();
      check("c2_burst_start", 32'(burst_start), 32'd1);
      check("c2_start_addr", 32'(burst_start_addr), 32'h10);
      cyc();
      check("c3_arm_stale_valid", 32'(out_valid), 32'd0);
      cyc();
      check("c4_out_valid", 32'(out_valid), 32'd1);
      exp_done = 1;
      wait_done(exp_done, 20);
      check("single_hs", 32'(hs_cnt), 32'd4);
      check("single_bursts_done", 32'(bursts_done), 32'd1);

      // Backpressure: len 3 with out_ready 1,0,0,1,0,1
      out_ready = 1'b0;
      base = hs_cnt;
      push_desc(8'h40, 8'd3);
      n = 0;
      while (!out_valid && n < 20) begin
         cyc();
         n++;
      end
      check("bp_out_valid_seen", 32'(out_valid), 32'd1);
      pat = 6'b101001;
      for (int k = 0; k < 6; k++) begin
         out_ready = pat[k];
         cyc();
      end
      out_ready = 1'b0;
      repeat (3) cyc();
      check("bp_handshakes", 32'(hs_cnt - base), 32'd3);
      exp_done++;
      check("bp_done", 32'(done_cnt), 32'(exp_done));
      check("bp_bursts_done", 32'(bursts_done), 32'(exp_done));
      out_ready = 1'b1;

      // Table-driven descriptors, including zero length and address wrap
      for (int i = 0; i < 5; i++) begin
         s0 = start_cnt;
         push_desc(tbl[i].addr, tbl[i].len);
         exp_done++;
         wait_done(exp_done, 40);
         check("tbl_start_cnt", 32'(start_cnt - s0), 32'(tbl[i].exp_start));
         if (tbl[i].exp_start) check("tbl_start_addr", 32'(last_start_addr), 32'(tbl[i].addr));
         check("tbl_bursts_done", 32'(bursts_done), 32'(exp_done));
      end

      // Queue full under downstream stall
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_desc(8'h50 + ADDR_W'(8 * i), 8'd2);
      check("full_q_level", 32'(q_level), 32'd4);
      check("full_desc_ready", 32'(desc_ready), 32'd0);
      out_ready = 1'b1;
      exp_done += 5;
      wait_done(exp_done, 100);
      check("full_bursts_done", 32'(bursts_done), 32'(exp_done));
      check("full_queue_drained", 32'(exp_q.size()), 32'd0);

      // Abort mid-burst with two descriptors queued
      out_ready = 1'b0;
      push_desc(8'h90, 8'd8);
      push_desc(8'hA0, 8'd2);
      push_desc(8'hB0, 8'd2);
      check("abort_q_level_before", 32'(q_level), 32'd2);
      base = hs_cnt;
      out_ready = 1'b1;
      n = 0;
      while (hs_cnt - base < 3 && n < 30) begin
         cyc();
         n++;
      end
      s0 = start_cnt;
      abort = 1'b1;
      #1;
      check("abort_desc_ready", 32'(desc_ready), 32'd0);
      check("abort_cycle_out_valid", 32'(out_valid), 32'd1);
      cyc();
      abort = 1'b0;
      check("abort_hs_delivered", 32'(hs_cnt - base), 32'd4);
      check("abort_q_flushed", 32'(q_level), 32'd0);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      repeat (3) cyc();
      check("abort_no_done", 32'(done_cnt), 32'(exp_done));
      check("abort_bursts_done", 32'(bursts_done), 32'(exp_done));
      check("abort_no_restart", 32'(start_cnt), 32'(s0));
      exp_q.delete();
      in_burst = 1'b0;
      push_desc(8'hC0, 8'd3);
      exp_done++;
      wait_done(exp_done, 30);
      check("post_abort_addr", 32'(last_start_addr), 32'hC0);
      check("post_abort_bursts", 32'(bursts_done), 32'(exp_done));

      // Asynchronous reset in the middle of a stream
      base = hs_cnt;
      push_desc(8'hD0, 8'd6);
      n = 0;
      while (hs_cnt - base < 2 && n < 30) begin
         cyc();
         n++;
      end
      check("arst_streaming", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_rd_ready", 32'(rd_ready), 32'd0);
      check("arst_burst_start", 32'(burst_start), 32'd0);
      exp_q.delete();
      in_burst = 1'b0;
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();
      check("arst_q_level", 32'(q_level), 32'd0);
      check("arst_bursts_done", 32'(bursts_done), 32'd0);
      check("arst_desc_ready", 32'(desc_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
